// File: rtl/vga_stream_sink.sv
// Avalon-ST pixel sink feeding a VGA DAC: show-ahead beat FIFO, free-running raster,
// and a SEARCH/ALIGN/RUN lock machine that pins each frame's first beat to raster (0,0).
module vga_stream_sink #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [29:0]                   data,
  input  logic                          startofpacket,
  input  logic                          endofpacket,
  input  logic                          valid,
  output logic                          ready,
  output logic [7:0]                    vga_r,
  output logic [7:0]                    vga_g,
  output logic [7:0]                    vga_b,
  output logic                          vga_hs,
  output logic                          vga_vs,
  output logic                          vga_blank_n,
  output logic                          locked,
  output logic                          underflow,
  output logic                          frame_err,
  output logic [1:0]                    dbg_state,
  output logic [$clog2(FIFO_DEPTH):0]   dbg_count,
  output logic [31:0]                   dbg_head
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic [31:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [31:0]     head;
  logic            head_sop;
  logic            head_eop;
  logic            empty;
  logic            push;
  logic            pop;
  logic            emit;
  logic            set_uf;
  logic            set_fe;
  logic            visible;
  logic            origin;
  logic            last_px;
  logic            hs_zone;
  logic            vs_zone;

  // Raster counters free-run in every state so sync is valid straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == HW'(H_TOTAL - 1)) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign visible = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign origin  = (h_cnt == '0) && (v_cnt == '0);
  assign last_px = (h_cnt == HW'(H_ACTIVE - 1)) && (v_cnt == VW'(V_ACTIVE - 1));
  assign hs_zone = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_zone = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC));

  // Handshake: a beat transfers on any rising clk edge where valid && ready.
  // ready depends only on the registered count, never on this cycle's pop.
  assign ready    = (count != CW'(FIFO_DEPTH));
  assign push     = valid && ready;
  assign empty    = (count == '0);
  assign head     = mem[rd_ptr];
  assign head_sop = head[31];
  assign head_eop = head[30];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {startofpacket, endofpacket, data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A sop at the head must coincide exactly with (0,0); either mismatch is a framing error.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    emit      = 1'b0;
    set_uf    = 1'b0;
    set_fe    = 1'b0;
    unique case (state)
      SEARCH: begin
        if (!empty) begin
          if (head_sop) state_nxt = ALIGN;
          else          pop = 1'b1;
        end
      end
      ALIGN: begin
        if (origin && !empty) begin
          pop       = 1'b1;
          emit      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (visible) begin
          if (empty) begin
            set_uf    = 1'b1;
            state_nxt = SEARCH;
          end else if (head_sop != origin) begin
            set_fe    = 1'b1;
            state_nxt = SEARCH;
          end else begin
            pop  = 1'b1;
            emit = 1'b1;
            if (last_px && !head_eop) begin
              set_fe    = 1'b1;
              state_nxt = SEARCH;
            end
          end
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Every pin is registered from the same counter state, keeping colour and sync aligned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      locked      <= 1'b0;
      underflow   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      vga_r       <= emit ? head[29:22] : 8'h00;
      vga_g       <= emit ? head[19:12] : 8'h00;
      vga_b       <= emit ? head[9:2]   : 8'h00;
      vga_hs      <= !hs_zone;
      vga_vs      <= !vs_zone;
      vga_blank_n <= visible;
      locked      <= (state_nxt == RUN);
      if (set_uf) underflow <= 1'b1;
      if (set_fe) frame_err <= 1'b1;
    end
  end

  assign dbg_state = state;
  assign dbg_count = count;
  assign dbg_head  = head;

endmodule

// File: tb/tb_vga_stream_sink.sv
// Bench for vga_stream_sink on a shrunken 16x8 raster (8x4 visible) so whole frames fit
// in a short run; a queue-based model of the sink predicts every registered output.
module tb_vga_stream_sink;

  localparam int HA    = 8;
  localparam int HFP   = 2;
  localparam int HSY   = 3;
  localparam int HBP   = 3;
  localparam int VA    = 4;
  localparam int VFP   = 1;
  localparam int VSY   = 2;
  localparam int VBP   = 1;
  localparam int DEPTH = 16;
  localparam int HT    = HA + HFP + HSY + HBP;
  localparam int VT    = VA + VFP + VSY + VBP;
  localparam int FRAME = HT * VT;
  localparam int FP    = HA * VA;

  localparam logic [30:0] RST_VEC = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  localparam int M_HUNT = 0;
  localparam int M_WAIT = 1;
  localparam int M_SHOW = 2;

  logic        clk;
  logic        reset;
  logic [29:0] data;
  logic        startofpacket;
  logic        endofpacket;
  logic        valid;
  logic        ready;
  logic [7:0]  vga_r;
  logic [7:0]  vga_g;
  logic [7:0]  vga_b;
  logic        vga_hs;
  logic        vga_vs;
  logic        vga_blank_n;
  logic        locked;
  logic        underflow;
  logic        frame_err;
  logic [1:0]  dbg_state;
  logic [4:0]  dbg_count;
  logic [31:0] dbg_head;
  logic [30:0] got_vec;

  int total;
  int bad;

  vga_stream_sink #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .data(data), .startofpacket(startofpacket),
    .endofpacket(endofpacket), .valid(valid), .ready(ready),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .locked(locked), .underflow(underflow),
    .frame_err(frame_err), .dbg_state(dbg_state), .dbg_count(dbg_count),
    .dbg_head(dbg_head)
  );

  assign got_vec = {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n,
                    locked, underflow, frame_err, ready};

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: raster position from elapsed cycles, FIFO as a queue of {sop,eop,data}
  logic [31:0] m_q[$];
  logic [31:0] m_beat;
  logic [30:0] exp_vec;
  int          m_t;
  int          m_mode;
  int          m_h;
  int          m_v;
  bit          m_emit;
  bit          m_uf;
  bit          m_fe;
  bit          m_vis;
  bit          m_org;
  bit          m_lst;
  bit          m_full;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_t = 0;
      m_q.delete();
      m_mode = M_HUNT;
      m_uf = 1'b0;
      m_fe = 1'b0;
      m_emit = 1'b0;
      m_h = 0;
      m_v = 0;
      exp_vec = RST_VEC;
    end else begin
      m_h    = m_t % HT;
      m_v    = (m_t / HT) % VT;
      m_vis  = (m_h < HA) && (m_v < VA);
      m_org  = (m_h == 0) && (m_v == 0);
      m_lst  = (m_h == HA - 1) && (m_v == VA - 1);
      m_full = (m_q.size() == DEPTH);
      m_emit = 1'b0;
      m_beat = '0;
      if (m_mode == M_HUNT) begin
        if (m_q.size() != 0) begin
          if (m_q[0][31]) m_mode = M_WAIT;
          else            void'(m_q.pop_front());
        end
      end else if (m_mode == M_WAIT) begin
        if (m_org) begin
          m_beat = m_q.pop_front();
          m_emit = 1'b1;
          m_mode = M_SHOW;
        end
      end else if (m_vis) begin
        if (m_q.size() == 0) begin
          m_uf = 1'b1;
          m_mode = M_HUNT;
        end else if (m_q[0][31] && !m_org) begin
          m_fe = 1'b1;
          m_mode = M_HUNT;
        end else if (m_org && !m_q[0][31]) begin
          m_fe = 1'b1;
          m_mode = M_HUNT;
        end else begin
          m_beat = m_q.pop_front();
          m_emit = 1'b1;
          if (m_lst && !m_beat[30]) begin
            m_fe = 1'b1;
            m_mode = M_HUNT;
          end
        end
      end
      if (valid && !m_full) m_q.push_back({startofpacket, endofpacket, data});
      exp_vec = {m_emit ? m_beat[29:22] : 8'h00,
                 m_emit ? m_beat[19:12] : 8'h00,
                 m_emit ? m_beat[9:2]   : 8'h00,
                 !((m_h >= HA + HFP) && (m_h < HA + HFP + HSY)),
                 !((m_v >= VA + VFP) && (m_v < VA + VFP + VSY)),
                 m_vis, (m_mode == M_SHOW), m_uf, m_fe, (m_q.size() != DEPTH)};
      m_t++;
    end
  end

  // Source driver: beat k of a frame carries red = k, random green/blue
  int          src_k;
  int          src_frame;
  int          src_sum;
  int          acc_cnt;
  int          inj_at;
  bit          src_on;
  bit          acc_pending;
  logic [29:0] cur_data;
  logic [29:0] inj_data;

  task automatic new_beat();
    logic [7:0] g;
    logic [7:0] b;
    g = 8'($urandom);
    b = 8'($urandom);
    cur_data = {8'(src_k), 2'b00, g, 2'b00, b, 2'b00};
    if (src_frame < 2) src_sum += src_k + int'(g) + int'(b);
  endtask

  task automatic drive_cycle();
    bit inj_now;
    inj_now = 1'b0;
    @(negedge clk);
    if (acc_pending) begin
      acc_cnt++;
      src_k++;
      if (src_k == inj_at) begin
        src_k   = 0;
        inj_at  = -1;
        inj_now = 1'b1;
      end else if (src_k == FP) begin
        src_k = 0;
        src_frame++;
      end
      new_beat();
      if (inj_now) inj_data = cur_data;
    end
    valid         = src_on;
    startofpacket = (src_k == 0);
    endofpacket   = (src_k == FP - 1);
    data          = cur_data;
    acc_pending   = valid && ready && reset;
  endtask

  task automatic do_reset(input int start_k);
    reset         = 1'b0;
    src_on        = 1'b0;
    valid         = 1'b0;
    startofpacket = 1'b0;
    endofpacket   = 1'b0;
    acc_pending   = 1'b0;
    src_k         = start_k;
    src_frame     = 0;
    src_sum       = 0;
    acc_cnt       = 0;
    inj_at        = -1;
    new_beat();
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    src_on = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if (got_vec !== RST_VEC) begin
      bad++; $display("FAIL reset_outputs got=%h exp=%h", got_vec, RST_VEC);
    end
    total++;
    if (dbg_count !== 5'd0) begin
      bad++; $display("FAIL reset_count got=%0d exp=0", dbg_count);
    end
    total++;
    if (dbg_state !== 2'd0) begin
      bad++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
  endtask

  task automatic test_continuous();
    int hs_low;
    int lock_t;
    hs_low = 0;
    lock_t = -1;
    do_reset(0);
    for (int i = 0; i < 3 * FRAME; i++) begin
      drive_cycle();
      total++;
      if (got_vec !== exp_vec) begin
        bad++; $display("FAIL cont_vec t=%0d got=%h exp=%h", m_t - 1, got_vec, exp_vec);
      end
      if (!vga_hs) hs_low++;
      if (locked && lock_t < 0) lock_t = m_t - 1;
      if (m_emit) begin
        total++;
        if (vga_r !== 8'(m_v * HA + m_h)) begin
          bad++; $display("FAIL cont_pixel_index h=%0d v=%0d got=%0d exp=%0d", m_h, m_v, vga_r, m_v * HA + m_h);
        end
      end
    end
    total++;
    if (lock_t != FRAME) begin
      bad++; $display("FAIL cont_lock_time got=%0d exp=%0d", lock_t, FRAME);
    end
    total++;
    if (hs_low != 3 * VT * HSY) begin
      bad++; $display("FAIL cont_hs_low_cycles got=%0d exp=%0d", hs_low, 3 * VT * HSY);
    end
    total++;
    if ({underflow, frame_err} !== 2'b00) begin
      bad++; $display("FAIL cont_flags got=%b exp=00", {underflow, frame_err});
    end
  endtask

  task automatic test_backpressure();
    int idle;
    int prev_acc;
    int disp_sum;
    idle     = $urandom_range(0, 40);
    prev_acc = 0;
    disp_sum = 0;
    do_reset(0);
    src_on = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      if (i == idle) src_on = 1'b1;
      drive_cycle();
      total++;
      if (got_vec !== exp_vec) begin
        bad++; $display("FAIL bp_vec t=%0d got=%h exp=%h", m_t - 1, got_vec, exp_vec);
      end
      if (acc_cnt == 15 && prev_acc == 14) begin
        total++;
        if (ready !== 1'b1) begin
          bad++; $display("FAIL bp_ready_at_15 got=%b exp=1", ready);
        end
      end
      if (acc_cnt == 16 && prev_acc == 15) begin
        total++;
        if (ready !== 1'b0) begin
          bad++; $display("FAIL bp_ready_at_16 got=%b exp=0", ready);
        end
      end
      prev_acc = acc_cnt;
      disp_sum += int'(vga_r) + int'(vga_g) + int'(vga_b);
    end
    total++;
    if (disp_sum != src_sum) begin
      bad++; $display("FAIL bp_checksum got=%0d exp=%0d", disp_sum, src_sum);
    end
  endtask

  task automatic test_mid_start();
    int lock_t;
    lock_t = -1;
    do_reset(10);
    for (int i = 0; i < 3 * FRAME; i++) begin
      drive_cycle();
      total++;
      if (got_vec !== exp_vec) begin
        bad++; $display("FAIL mid_vec t=%0d got=%h exp=%h", m_t - 1, got_vec, exp_vec);
      end
      if (locked && lock_t < 0) lock_t = m_t - 1;
      if (m_emit) begin
        total++;
        if (vga_r !== 8'(m_v * HA + m_h)) begin
          bad++; $display("FAIL mid_pixel_index h=%0d v=%0d got=%0d exp=%0d", m_h, m_v, vga_r, m_v * HA + m_h);
        end
      end
    end
    total++;
    if (lock_t != FRAME) begin
      bad++; $display("FAIL mid_lock_time got=%0d exp=%0d", lock_t, FRAME);
    end
    total++;
    if ({locked, underflow, frame_err} !== 3'b100) begin
      bad++; $display("FAIL mid_final got=%b exp=100", {locked, underflow, frame_err});
    end
  endtask

  task automatic test_underflow();
    int phase;
    int stall;
    bit seen_uf;
    phase   = 0;
    stall   = 0;
    seen_uf = 1'b0;
    do_reset(0);
    for (int i = 0; i < 5 * FRAME; i++) begin
      drive_cycle();
      total++;
      if (got_vec !== exp_vec) begin
        bad++; $display("FAIL uf_vec t=%0d got=%h exp=%h", m_t - 1, got_vec, exp_vec);
      end
      if (phase == 0 && m_mode == M_SHOW && m_v == 1 && m_h == 0) begin
        phase  = 1;
        stall  = 4 * HT;
        src_on = 1'b0;
      end else if (phase == 1) begin
        stall--;
        if (stall == 0) begin
          src_on = 1'b1;
          phase  = 2;
        end
      end
      if (m_uf && !seen_uf) begin
        seen_uf = 1'b1;
        total++;
        if ({underflow, locked, vga_r, vga_g, vga_b} !== {1'b1, 1'b0, 24'h0}) begin
          bad++; $display("FAIL uf_event got uf=%b lk=%b rgb=%h exp uf=1 lk=0 rgb=000000", underflow, locked, {vga_r, vga_g, vga_b});
        end
      end
    end
    total++;
    if ({locked, underflow} !== 2'b11) begin
      bad++; $display("FAIL uf_relock got=%b exp=11", {locked, underflow});
    end
  endtask

  task automatic test_misplaced_sop();
    int phase;
    phase = 0;
    do_reset(0);
    for (int i = 0; i < 4 * FRAME; i++) begin
      drive_cycle();
      total++;
      if (got_vec !== exp_vec) begin
        bad++; $display("FAIL sop_vec t=%0d got=%h exp=%h", m_t - 1, got_vec, exp_vec);
      end
      if (phase == 0 && m_mode == M_SHOW) begin
        inj_at = 20;
        phase  = 1;
      end else if (phase == 1 && m_fe) begin
        phase = 2;
        total++;
        if ({frame_err, locked} !== 2'b10) begin
          bad++; $display("FAIL sop_error got=%b exp=10", {frame_err, locked});
        end
      end else if (phase == 2 && m_emit && m_h == 0 && m_v == 0) begin
        phase = 3;
        total++;
        if ({vga_r, vga_g, vga_b} !== {inj_data[29:22], inj_data[19:12], inj_data[9:2]}) begin
          bad++; $display("FAIL sop_retained got=%h exp=%h", {vga_r, vga_g, vga_b},
                          {inj_data[29:22], inj_data[19:12], inj_data[9:2]});
        end
      end
    end
    total++;
    if ({locked, frame_err} !== 2'b11) begin
      bad++; $display("FAIL sop_final got=%b exp=11", {locked, frame_err});
    end
  endtask

  task automatic test_mid_reset();
    bit hit;
    hit = 1'b0;
    do_reset(0);
    for (int i = 0; i < 3 * FRAME && !hit; i++) begin
      drive_cycle();
      total++;
      if (got_vec !== exp_vec) begin
        bad++; $display("FAIL mrst_vec t=%0d got=%h exp=%h", m_t - 1, got_vec, exp_vec);
      end
      if (m_mode == M_SHOW && m_h == 5 && m_v == 2) hit = 1'b1;
    end
    total++;
    if (!hit || locked !== 1'b1) begin
      bad++; $display("FAIL mrst_reach_point got hit=%b locked=%b exp hit=1 locked=1", hit, locked);
    end
    #2;
    reset       = 1'b0;
    src_on      = 1'b0;
    valid       = 1'b0;
    acc_pending = 1'b0;
    #1;
    total++;
    if (got_vec !== RST_VEC) begin
      bad++; $display("FAIL mrst_async_outputs got=%h exp=%h", got_vec, RST_VEC);
    end
    total++;
    if ({dbg_count, dbg_state} !== 7'd0) begin
      bad++; $display("FAIL mrst_fifo_state got count=%0d state=%0d exp 0 0", dbg_count, dbg_state);
    end
    repeat (3) @(negedge clk);
    src_k     = 0;
    src_frame = 0;
    new_beat();
    reset  = 1'b1;
    src_on = 1'b1;
    drive_cycle();
    total++;
    if ({vga_blank_n, vga_hs, vga_vs} !== 3'b111) begin
      bad++; $display("FAIL mrst_restart_origin got=%b exp=111", {vga_blank_n, vga_hs, vga_vs});
    end
    for (int i = 0; i < 2 * FRAME; i++) begin
      drive_cycle();
      total++;
      if (got_vec !== exp_vec) begin
        bad++; $display("FAIL mrst_after_vec t=%0d got=%h exp=%h", m_t - 1, got_vec, exp_vec);
      end
    end
    total++;
    if ({locked, underflow, frame_err} !== 3'b100) begin
      bad++; $display("FAIL mrst_relock got=%b exp=100", {locked, underflow, frame_err});
    end
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset         = 1'b0;
    valid         = 1'b0;
    startofpacket = 1'b0;
    endofpacket   = 1'b0;
    data          = '0;
    src_on        = 1'b0;
    acc_pending   = 1'b0;
    inj_at        = -1;
    inj_data      = '0;
    cur_data      = '0;
    test_reset();
    test_continuous();
    test_backpressure();
    test_mid_start();
    test_underflow();
    test_misplaced_sop();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
